// File: rtl/rate_ram_scanner_pkg.sv
// Shared sizing for the spike-rate RAM and the scanner FSM state encoding.
package rate_ram_scanner_pkg;

    localparam int RR_CH_BIT         = 2;
    localparam int RR_CH_NUM         = 4;
    localparam int RR_SPIKE_RATE_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } scan_state_t;

endpackage

// File: rtl/rate_ram_scanner_if.sv
// Record stream from the scanner toward the compression/packetiser stage.
interface rate_ram_scanner_if
    import rate_ram_scanner_pkg::*;
#(
    parameter int CH_BIT = RR_CH_BIT,
    parameter int DATA_W = 2 * RR_SPIKE_RATE_BIT
);
    logic              valid;
    logic              ready;
    logic [CH_BIT-1:0] ch;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ch, output data, input ready);
    modport slave  (input valid, input ch, input data, output ready);
endinterface

// File: rtl/rate_ram_scanner.sv
// Frame-tick sweep of the spike-rate RAM emitting (channel, rate) records; SCAN_CLEAR_EN makes each read also clear the entry.
// Latency: first record valid 3 cycles after tick; 3 cycles per emitted channel, 2 per skipped zero channel.
// Backpressure: a record is held stable until valid&&ready; the sweep waits, and ticks arriving while busy raise overrun.
module rate_ram_scanner
    import rate_ram_scanner_pkg::*;
#(
    parameter int CH_BIT    = RR_CH_BIT,
    parameter int CH_NUM    = RR_CH_NUM,
    parameter int DATA_W    = 2 * RR_SPIKE_RATE_BIT,
    parameter int SKIP_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    output logic [CH_BIT-1:0]    ram_raddr,
    input  logic [DATA_W-1:0]    ram_dout,
    output logic                 ram_we,
    output logic [CH_BIT-1:0]    ram_waddr,
    output logic [DATA_W-1:0]    ram_din,
    rate_ram_scanner_if.master   out,
    output logic                 scan_busy,
    output logic                 scan_done,
    output logic                 overrun
);

    localparam logic [CH_BIT-1:0] LAST_CH = CH_BIT'(CH_NUM - 1);

    scan_state_t       state;
    logic [CH_BIT-1:0] ch;
    logic              skip_word;
    logic              at_last;
    logic              advance;

    assign ram_raddr = ch;
    assign skip_word = (SKIP_ZERO != 0) && (ram_dout == '0);
    assign at_last   = (ch == LAST_CH);
    // Move to the next channel after a skipped capture or an accepted record.
    assign advance   = ((state == ST_CAP) && skip_word) ||
                       ((state == ST_SEND) && out.ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ch        <= '0;
            out.valid <= 1'b0;
            out.ch    <= '0;
            out.data  <= '0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            overrun   <= frame_tick && (state != ST_IDLE);
            if (advance) begin
                out.valid <= 1'b0;
                if (at_last) begin
                    state     <= ST_DONE;
                    scan_done <= 1'b1;
                    scan_busy <= 1'b0;
                end else begin
                    ch    <= ch + CH_BIT'(1);
                    state <= ST_RD;
                end
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (frame_tick) begin
                            ch        <= '0;
                            scan_busy <= 1'b1;
                            state     <= ST_RD;
                        end
                    end
                    ST_RD: state <= ST_CAP;
                    ST_CAP: begin
                        out.data  <= ram_dout;
                        out.ch    <= ch;
                        out.valid <= 1'b1;
                        state     <= ST_SEND;
                    end
                    ST_SEND: state <= ST_SEND;
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SCAN_CLEAR_EN
    // The write lands in the CAP cycle, after the read of the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_waddr <= '0;
        end else begin
            ram_we    <= (state == ST_RD);
            ram_waddr <= ch;
        end
    end
`else
    assign ram_we    = 1'b0;
    assign ram_waddr = '0;
`endif
    assign ram_din = '0;

endmodule

// File: doc/rate_ram_scanner.md
Name: rate_ram_scanner

Overview:
- Read-side client of the per-channel spike-rate dual-port RAM (CH_NUM entries, 2*SPIKE_RATE_BIT wide, 1-cycle registered read).
- On each frame tick it sweeps all channel addresses and captures each entry.
- It emits (channel, rate word) records on a valid/ready stream toward the compression/packetiser stage, optionally suppressing zero-rate channels.
- The RAM read clock is tied to clk at top level.

Parameters:
- CH_BIT, `CH_BIT, channel address width
- CH_NUM, `CH_NUM, number of channels scanned (addresses 0..CH_NUM-1)
- DATA_W, `SPIKE_RATE_BIT*2, RAM word width
- SKIP_ZERO, 1, 1 = channels whose word is all-zero are not emitted

Ports:
- clk  in  1  single system clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse requesting a full scan
- ram_raddr  out  CH_BIT  RAM read address
- ram_dout  in  DATA_W  RAM read data, valid one cycle after address
- ram_we  out  1  RAM write enable (clear feature only)
- ram_waddr  out  CH_BIT  RAM write address
- ram_din  out  DATA_W  RAM write data
- out_valid  out  1  record valid
- out_ready  in  1  downstream accept
- out_ch  out  CH_BIT  channel index of record
- out_data  out  DATA_W  rate word of record
- scan_busy  out  1  high from tick acceptance until scan end
- scan_done  out  1  one-cycle pulse at scan end
- overrun  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Reset values: state IDLE; ch counter 0; ram_raddr 0; out_valid 0; out_ch 0; out_data 0; scan_busy 0; scan_done 0; overrun 0; ram_we 0; ram_waddr 0; ram_din 0.
- Reset is asynchronous and may occur mid-scan. The scan is abandoned with no further records and no scan_done; an out_valid held at reset time drops immediately.
- ram_raddr equals the registered ch counter at all times.
- FSM states:
  - IDLE: frame_tick=1 -> ch<=0, scan_busy<=1, go RD.
  - RD (1 cycle): RAM samples ram_raddr. Go CAP.
  - CAP (1 cycle): ram_dout is valid.
    - If SKIP_ZERO and ram_dout==0: ch==CH_NUM-1 -> DONE; else ch<=ch+1 -> RD.
    - Otherwise: out_data<=ram_dout, out_ch<=ch, out_valid<=1 -> SEND.
  - SEND: out_valid, out_ch and out_data are held stable until out_valid&&out_ready. On handshake: out_valid<=0; ch==CH_NUM-1 -> DONE; else ch<=ch+1 -> RD.
  - DONE: scan_done=1 and scan_busy<=0 for this one cycle; go IDLE. No wrap past CH_NUM-1.
- Latency: tick in cycle T -> out_valid high from cycle T+3. Minimum 3 cycles per emitted channel. A skipped channel costs 2 cycles.
- frame_tick in any non-IDLE state, including DONE, is dropped and overrun pulses the following cycle. A tick is never queued.
- out_ready asserted while out_valid=0 has no effect.
- A RAM write by the upstream writer to a not-yet-scanned channel during a scan is visible to the scan; the last channel read wins.

Optional Feature:
- Macro SCAN_CLEAR_EN.
- Defined: in every CAP cycle ram_we=1, ram_waddr=ch and ram_din=0, so each entry is read-and-cleared, including skipped zero entries. This gives per-frame rate reset.
- Not defined: ram_we, ram_waddr and ram_din are tied 0 and the RAM is read-only from this block. The top level owns write-port arbitration in both cases.

Decomposition:
- Shared params include (existing) supplies CH_BIT, CH_NUM and SPIKE_RATE_BIT.
- Add the FSM state encoding constants (IDLE, RD, CAP, SEND, DONE) to the shared include.
- No sub-module; a single flat FSM plus counter.

Test Plan (CH_NUM=4, DATA_W=8, RAM preloaded {0x11,0x00,0x33,0x44}, model RAM with 1-cycle read):
- SKIP_ZERO=1, out_ready=1, tick at T -> records (0,0x11)@T+3, (2,0x33), (3,0x44); channel 1 absent; scan_done pulses once; scan_busy drops the same cycle.
- SKIP_ZERO=0 -> four records ch 0..3 with data 0x11,0x00,0x33,0x44 in order.
- out_ready held low 5 cycles on (2,0x33) -> out_valid, out_ch and out_data stable throughout; exactly one record per handshake.
- Second tick while busy -> overrun pulses one cycle; exactly one scan occurs.
- rst_n low during SEND of ch 2 -> all outputs at reset values immediately; the next tick restarts at ch 0.
- SCAN_CLEAR_EN defined -> ram_we pulses 4 times with waddr 0..3 and din 0; a second scan with SKIP_ZERO=1 emits no records but still gives a scan_done pulse.
